// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths and the buffered write-request type
// used by the register-file write arbiter and its request buffers.
package regfile_write_arbiter_pkg;
    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/wr_req_fifo.sv
// wr_req_fifo: small write-request buffer that also exposes per-slot valid bits
// and destination addresses so the owner can build a pending-write mask.
module wr_req_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  logic                                  pop,
    input  wr_req_t                               din,
    output wr_req_t                               dout,
    output logic                                  full,
    output logic                                  empty,
    output logic [FIFO_DEPTH-1:0]                 vld,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] addrs
);
    localparam int PW = $clog2(FIFO_DEPTH);

    wr_req_t        mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Push and pop never target the same slot: that would need a full or empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) addrs[i] = mem[i].addr;
    end

    assign dout  = mem[rd_ptr];
    assign full  = &vld;
    assign empty = ~|vld;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between writeback (A,
// preferred) and load return (B), with a starvation guard for B and a pending-write mask.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = REG_DATA_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [DATA_W-1:0]    b_data,
    output logic [ADDR_W-1:0]    rf_addr,
    output logic [DATA_W-1:0]    rf_data,
    output logic                 rf_write,
    output logic                 grant_b,
    output logic [2**ADDR_W-1:0] busy_mask
);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    wr_req_t                               a_req, b_req, a_head, b_head, win;
    logic                                  a_full, a_empty, b_full, b_empty;
    logic                                  a_push, b_push, a_pop, b_pop, rdy_en;
    logic [FIFO_DEPTH-1:0]                 a_vld, b_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] a_addrs, b_addrs;
    logic [SW-1:0]                         starve;

    assign a_req = '{addr: a_addr, data: a_data};
    assign b_req = '{addr: b_addr, data: b_data};

    wr_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_a_fifo (
        .clk(clk), .rst_n(rst_n), .push(a_push), .pop(a_pop), .din(a_req), .dout(a_head),
        .full(a_full), .empty(a_empty), .vld(a_vld), .addrs(a_addrs)
    );

    wr_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .din(b_req), .dout(b_head),
        .full(b_full), .empty(b_empty), .vld(b_vld), .addrs(b_addrs)
    );

    // Holds readies low from reset until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    starve <= '0;
        else if (b_empty || grant_b)   starve <= '0;
        else if (starve < SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
    end

    assign a_ready  = rdy_en & ~a_full;
    assign b_ready  = rdy_en & ~b_full;
    assign a_push   = a_valid & a_ready;
    assign b_push   = b_valid & b_ready;
    assign grant_b  = ~b_empty & (a_empty | (starve >= SW'(STARVE_LIMIT)));
    assign rf_write = ~a_empty | ~b_empty;
    assign a_pop    = rf_write & ~grant_b;
    assign b_pop    = grant_b;
    assign win      = grant_b ? b_head : a_head;
    assign rf_addr  = rf_write ? win.addr : '0;
    assign rf_data  = rf_write ? win.data : '0;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (a_vld[i]) busy_mask[a_addrs[i]] = 1'b1;
            if (b_vld[i]) busy_mask[b_addrs[i]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: random and directed stimulus; accepted requests feed a
// queue-based reference model that a negedge monitor compares against the write port.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic        rf_write, grant_b;
    logic [7:0]  busy_mask;

    regfile_write_arbiter #(
        .DATA_W(REG_DATA_W), .ADDR_W(REG_ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_addr(rf_addr), .rf_data(rf_data), .rf_write(rf_write), .grant_b(grant_b),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    wr_req_t     qa[$], qb[$];
    int          starve = 0;
    bit          rdy = 0;
    bit          a_acc = 0, b_acc = 0;
    logic [15:0] dut_rf[NUM_REGS], mdl_rf[NUM_REGS];
    int          total = 0, bad = 0;
    int          a_mode = 3, b_mode = 3;
    logic [2:0]  fix_a = '0, fix_b = '0;
    int          gb_cnt, wr_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Acceptance is sampled with pre-edge values.
    always @(posedge clk) begin
        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;
        if (a_acc) qa.push_back('{addr: a_addr, data: a_data});
        if (b_acc) qb.push_back('{addr: b_addr, data: b_data});
        rdy = rst_n;
    end

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
        starve = 0;
        rdy = 0;
    end

    // Sources hold addr/data while a request is pending and unaccepted.
    always @(posedge clk) begin
        #1;
        if (a_mode != 3 && (!a_valid || a_acc)) begin
            a_valid = (a_mode == 2) || (a_mode == 1 && $urandom_range(0, 9) < 7);
            a_addr  = (a_mode == 2) ? fix_a : 3'($urandom_range(0, 7));
            a_data  = 16'($urandom);
        end
        if (b_mode != 3 && (!b_valid || b_acc)) begin
            b_valid = (b_mode == 2) || (b_mode == 1 && $urandom_range(0, 9) < 4);
            b_addr  = (b_mode == 2) ? fix_b : 3'($urandom_range(0, 7));
            b_data  = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        logic [7:0] em;
        bit         an, bn, gb;
        wr_req_t    h;
        em = '0;
        foreach (qa[i]) em[qa[i].addr] = 1'b1;
        foreach (qb[i]) em[qb[i].addr] = 1'b1;
        check("busy_mask", 32'(busy_mask), 32'(em));
        check("a_ready", 32'(a_ready), 32'(rdy && qa.size() < DEPTH));
        check("b_ready", 32'(b_ready), 32'(rdy && qb.size() < DEPTH));
        an = qa.size() != 0;
        bn = qb.size() != 0;
        gb = bn && (!an || starve >= LIMIT);
        check("rf_write", 32'(rf_write), 32'(an || bn));
        check("grant_b", 32'(grant_b), 32'(gb));
        if (an || bn) begin
            h = gb ? qb.pop_front() : qa.pop_front();
            check("rf_addr", 32'(rf_addr), 32'(h.addr));
            check("rf_data", 32'(rf_data), 32'(h.data));
            mdl_rf[h.addr] = h.data;
        end else begin
            check("rf_addr_idle", 32'(rf_addr), 32'd0);
            check("rf_data_idle", 32'(rf_data), 32'd0);
        end
        starve = (!bn || gb) ? 0 : (starve < LIMIT ? starve + 1 : starve);
        if (rf_write) dut_rf[rf_addr] = rf_data;
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            dut_rf[i] = '0;
            mdl_rf[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_rf_write", 32'(rf_write), 32'd0);
        #2 rst_n = 1'b1;

        // Single A write: visible the cycle after acceptance, mask clears a cycle later.
        tick();
        a_valid = 1'b1; a_addr = 3'd3; a_data = 16'hBEEF;
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        check("beef_write", 32'(rf_write), 32'd1);
        check("beef_addr", 32'(rf_addr), 32'd3);
        check("beef_data", 32'(rf_data), 32'hBEEF);
        check("beef_mask", 32'(busy_mask), 32'h08);
        @(negedge clk);
        check("beef_mask_clear", 32'(busy_mask), 32'h00);
        check("beef_idle", 32'(rf_write), 32'd0);

        // Both always valid: four A grants, then one forced B grant, repeating.
        tick();
        fix_a = 3'd1; fix_b = 3'd2;
        a_valid = 1'b1; a_addr = fix_a; a_data = 16'h1111;
        b_valid = 1'b1; b_addr = fix_b; b_data = 16'h2222;
        a_mode = 2; b_mode = 2;
        tick();
        gb_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            gb_cnt += int'(grant_b);
        end
        check("starve_pattern", 32'(gb_cnt), 32'd3);
        a_mode = 0; b_mode = 0;
        repeat (12) tick();

        // Same register from both sides: A first, B last, B's value persists.
        a_mode = 3; b_mode = 3;
        a_valid = 1'b1; a_addr = 3'd5; a_data = 16'd1;
        b_valid = 1'b1; b_addr = 3'd5; b_data = 16'd2;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) tick();
        check("same_reg_final", 32'(dut_rf[5]), 32'd2);

        // Reset mid-cycle with writes pending.
        fix_a = 3'd6; fix_b = 3'd7;
        a_mode = 2; b_mode = 2;
        repeat (3) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        a_mode = 3; b_mode = 3;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check("mid_rst_write", 32'(rf_write), 32'd0);
        check("mid_rst_mask", 32'(busy_mask), 32'd0);
        check("mid_rst_a_ready", 32'(a_ready), 32'd0);
        check("mid_rst_b_ready", 32'(b_ready), 32'd0);
        check("mid_rst_grant_b", 32'(grant_b), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_cnt += int'(rf_write);
        end
        check("post_rst_no_write", 32'(wr_cnt), 32'd0);

        // Random traffic against the reference model.
        tick();
        a_mode = 1; b_mode = 1;
        repeat (3000) tick();
        a_mode = 0; b_mode = 0;
        repeat (12) tick();
        for (int i = 0; i < NUM_REGS; i++) check("rf_contents", 32'(dut_rf[i]), 32'(mdl_rf[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
